// File: rtl/uart_frame_decoder_if.sv
// Byte-stream, header and payload signals of the frame decoder.
// master is the decoder's view; slave is the view of the surrounding logic.
interface uart_frame_decoder_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] hdr_cmd;
  logic [7:0] hdr_len;
  logic       hdr_valid;
  logic       hdr_ready;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_last;
  logic       pl_ready;
  logic       frame_done;
  logic [1:0] frame_err;

  modport master (
    input  in_data, in_valid, hdr_ready, pl_ready,
    output in_ready, hdr_cmd, hdr_len, hdr_valid,
           pl_data, pl_valid, pl_last, frame_done, frame_err
  );

  modport slave (
    output in_data, in_valid, hdr_ready, pl_ready,
    input  in_ready, hdr_cmd, hdr_len, hdr_valid,
           pl_data, pl_valid, pl_last, frame_done, frame_err
  );
endinterface

// File: rtl/uart_frame_decoder.sv
// Splits SYNC/CMD/LEN/payload/CHK frames into a held header and a zero-latency payload stream.
// Header is held until hdr_ready; payload stalls (pl_ready=0) block the input and never time out.
module uart_frame_decoder #(
  parameter int         CLK_FREQ       = 10_000_000,
  parameter int         TIMEOUT_CYCLES = CLK_FREQ / 100,
  parameter int         MAX_LEN        = 64,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input logic clk,
  input logic rst,
  uart_frame_decoder_if.master bus
);
  localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]       LEN_MAX  = 9'(MAX_LEN);

  localparam logic [1:0] ERR_OK = 2'd0, ERR_CHK = 2'd1, ERR_LEN = 2'd2, ERR_TMO = 2'd3;

  typedef enum logic [2:0] {HUNT, CMD, LEN, HDR, PAYLOAD, CSUM} state_t;

  state_t           state, state_nxt;
  logic [7:0]       acc, acc_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic [7:0]       cmd_q, cmd_nxt;
  logic [7:0]       len_q, len_nxt;
  logic [TMO_W-1:0] tmo, tmo_nxt;
  logic             hdr_vld_q, hdr_vld_nxt;
  logic             done_q, done_nxt;
  logic [1:0]       err_q, err_nxt;
  logic             ready, accept, tmo_live;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HUNT;
      acc       <= '0;
      cnt       <= '0;
      cmd_q     <= '0;
      len_q     <= '0;
      tmo       <= '0;
      hdr_vld_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= ERR_OK;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      cmd_q     <= cmd_nxt;
      len_q     <= len_nxt;
      tmo       <= tmo_nxt;
      hdr_vld_q <= hdr_vld_nxt;
      done_q    <= done_nxt;
      err_q     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    cnt_nxt     = cnt;
    cmd_nxt     = cmd_q;
    len_nxt     = len_q;
    tmo_nxt     = tmo;
    hdr_vld_nxt = hdr_vld_q;
    done_nxt    = 1'b0;
    err_nxt     = err_q;

    case (state)
      HUNT, CMD, LEN, CSUM: ready = 1'b1;
      PAYLOAD:              ready = bus.pl_ready;
      default:              ready = 1'b0;
    endcase
    accept = bus.in_valid && ready;

    // A payload stall (pl_ready=0) freezes the timer so slow consumers never abort a frame.
    tmo_live = (state inside {CMD, LEN, CSUM}) || (state == PAYLOAD && bus.pl_ready);
    if (tmo_live) tmo_nxt = tmo + TMO_W'(1);
    if (accept)   tmo_nxt = '0;

    if (tmo_live && tmo == TMO_LAST) begin
      // Timeout wins over a byte arriving in the same cycle; that byte is dropped.
      done_nxt  = 1'b1;
      err_nxt   = ERR_TMO;
      state_nxt = HUNT;
    end else begin
      case (state)
        HUNT: if (accept && bus.in_data == SYNC_BYTE) begin
          acc_nxt   = '0;
          state_nxt = CMD;
        end
        CMD: if (accept) begin
          cmd_nxt   = bus.in_data;
          acc_nxt   = acc ^ bus.in_data;
          state_nxt = LEN;
        end
        LEN: if (accept) begin
          acc_nxt = acc ^ bus.in_data;
          if ({1'b0, bus.in_data} > LEN_MAX) begin
            done_nxt  = 1'b1;
            err_nxt   = ERR_LEN;
            state_nxt = HUNT;
          end else begin
            len_nxt     = bus.in_data;
            cnt_nxt     = bus.in_data;
            hdr_vld_nxt = 1'b1;
            state_nxt   = HDR;
          end
        end
        HDR: if (bus.hdr_ready) begin
          hdr_vld_nxt = 1'b0;
          state_nxt   = (len_q == 8'd0) ? CSUM : PAYLOAD;
        end
        PAYLOAD: if (accept) begin
          acc_nxt = acc ^ bus.in_data;
          cnt_nxt = cnt - 8'd1;
          if (cnt == 8'd1) state_nxt = CSUM;
        end
        CSUM: if (accept) begin
          done_nxt  = 1'b1;
          err_nxt   = (bus.in_data == acc) ? ERR_OK : ERR_CHK;
          state_nxt = HUNT;
        end
        default: state_nxt = HUNT;
      endcase
    end

    if (state_nxt == HUNT) tmo_nxt = '0;
  end

  assign bus.in_ready   = ready;
  assign bus.hdr_cmd    = cmd_q;
  assign bus.hdr_len    = len_q;
  assign bus.hdr_valid  = hdr_vld_q;
  assign bus.pl_data    = (state == PAYLOAD) ? bus.in_data : 8'h00;
  assign bus.pl_valid   = (state == PAYLOAD) && bus.in_valid;
  assign bus.pl_last    = (state == PAYLOAD) && (cnt == 8'd1);
  assign bus.frame_done = done_q;
  assign bus.frame_err  = err_q;
endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder: frame table plus back-pressure, timeout and reset sequences.
module tb_uart_frame_decoder;
  localparam int TMO   = 200;
  localparam int LIMIT = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_frame_decoder_if bus();

  uart_frame_decoder #(
    .CLK_FREQ(20_000), .TIMEOUT_CYCLES(TMO), .MAX_LEN(64), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Observed events, sampled late in the low phase so they match what the next edge sees.
  int         hdr_seen, done_seen;
  logic [7:0] hcmd, hlen;
  logic [1:0] derr;
  logic [7:0] plq[$];
  logic       lastq[$];

  initial forever begin
    @(negedge clk);
    #3;
    if (bus.hdr_valid && bus.hdr_ready) begin
      hdr_seen++;
      hcmd = bus.hdr_cmd;
      hlen = bus.hdr_len;
    end
    if (bus.pl_valid && bus.pl_ready) begin
      plq.push_back(bus.pl_data);
      lastq.push_back(bus.pl_last);
    end
    if (bus.frame_done) begin
      done_seen++;
      derr = bus.frame_err;
    end
  end

  task automatic clear_mon();
    hdr_seen  = 0;
    done_seen = 0;
    derr      = 2'd0;
    hcmd      = 8'h00;
    hlen      = 8'h00;
    plq.delete();
    lastq.delete();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called right after a falling edge; returns on the falling edge after the byte is taken.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && n < LIMIT) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= LIMIT) begin
      tests++;
      fails++;
      $display("FAIL send_byte: byte %0h not accepted in %0d cycles, required acceptance", b, LIMIT);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  typedef struct {
    int          n;
    logic [63:0] bytes;   // first byte in the top octet
    logic        hdr;
    logic [7:0]  cmd;
    logic [7:0]  len;
    int          npl;
    logic [31:0] pl;      // first payload byte in the top octet
    logic [1:0]  err;
  } vec_t;

  vec_t vecs[5];

  task automatic apply_vec(input vec_t v, input string tag);
    logic [63:0] bs;
    logic [31:0] ps;
    bs = v.bytes;
    ps = v.pl;
    clear_mon();
    for (int i = 0; i < v.n; i++) send_byte(bs[63 - 8*i -: 8]);
    repeat (4) @(negedge clk);
    check({tag, "_done_cnt"}, 32'(done_seen), 32'd1);
    check({tag, "_err"}, 32'(derr), 32'(v.err));
    check({tag, "_hdr_cnt"}, 32'(hdr_seen), v.hdr ? 32'd1 : 32'd0);
    if (v.hdr) begin
      check({tag, "_hdr_cmd"}, 32'(hcmd), 32'(v.cmd));
      check({tag, "_hdr_len"}, 32'(hlen), 32'(v.len));
    end
    check({tag, "_pl_cnt"}, 32'(plq.size()), 32'(v.npl));
    if (plq.size() == v.npl) begin
      for (int i = 0; i < v.npl; i++) begin
        check($sformatf("%s_pl%0d_data", tag, i), 32'(plq[i]), 32'(ps[31 - 8*i -: 8]));
        check($sformatf("%s_pl%0d_last", tag, i), 32'(lastq[i]), (i == v.npl - 1) ? 32'd1 : 32'd0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;

    //            n  bytes                   hdr  cmd    len    npl pl             err
    vecs[0] = '{6, 64'hA5_01_02_10_20_33_00_00, 1'b1, 8'h01, 8'h02, 2, 32'h10_20_00_00, 2'd0};
    vecs[1] = '{8, 64'h00_FF_A5_01_02_10_20_34, 1'b1, 8'h01, 8'h02, 2, 32'h10_20_00_00, 2'd1};
    vecs[2] = '{5, 64'hA5_03_01_55_57_00_00_00, 1'b1, 8'h03, 8'h01, 1, 32'h55_00_00_00, 2'd0};
    vecs[3] = '{3, 64'hA5_07_41_00_00_00_00_00, 1'b0, 8'h00, 8'h00, 0, 32'h0,          2'd2};
    vecs[4] = '{4, 64'hA5_07_00_07_00_00_00_00, 1'b1, 8'h07, 8'h00, 0, 32'h0,          2'd0};

    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.hdr_ready = 1'b1;
    bus.pl_ready  = 1'b1;
    clear_mon();

    #2 rst = 1'b0;
    #1;
    check("rst_hdr_valid", 32'(bus.hdr_valid), 32'd0);
    check("rst_frame_done", 32'(bus.frame_done), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("rst_hdr_cmd", 32'(bus.hdr_cmd), 32'd0);
    check("rst_hdr_len", 32'(bus.hdr_len), 32'd0);
    check("rst_pl_valid", 32'(bus.pl_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 5; k++) apply_vec(vecs[k], $sformatf("vec%0d", k));

    // Header held 50 cycles, then a 300-cycle payload stall longer than the timeout.
    clear_mon();
    bus.hdr_ready = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h02);
    bus.in_data  = 8'h11;
    bus.in_valid = 1'b1;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (bus.in_ready !== 1'b0 || bus.hdr_valid !== 1'b1 || bus.hdr_cmd !== 8'h02 ||
          bus.hdr_len !== 8'h02 || done_seen != 0) bad++;
      @(negedge clk);
    end
    check("bp_hdr_hold_bad_cycles", 32'(bad), 32'd0);
    bus.hdr_ready = 1'b1;
    send_byte(8'h11);
    bus.pl_ready = 1'b0;
    bus.in_data  = 8'h22;
    bus.in_valid = 1'b1;
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      #1;
      if (bus.in_ready !== 1'b0 || bus.pl_valid !== 1'b1 || bus.pl_last !== 1'b1 ||
          done_seen != 0) bad++;
      @(negedge clk);
    end
    check("bp_pl_stall_bad_cycles", 32'(bad), 32'd0);
    bus.pl_ready = 1'b1;
    send_byte(8'h22);
    send_byte(8'h33);
    repeat (4) @(negedge clk);
    check("bp_done_cnt", 32'(done_seen), 32'd1);
    check("bp_err", 32'(derr), 32'd0);
    check("bp_hdr_cnt", 32'(hdr_seen), 32'd1);
    check("bp_pl_cnt", 32'(plq.size()), 32'd2);
    if (plq.size() == 2) begin
      check("bp_pl0", 32'(plq[0]), 32'h11);
      check("bp_pl1", 32'(plq[1]), 32'h22);
      check("bp_pl1_last", 32'(lastq[1]), 32'd1);
    end

    // Inter-byte timeout: idle in LEN, pulse on the 200th idle edge.
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (TMO - 1) @(negedge clk);
    check("tmo_not_early", 32'(bus.frame_done), 32'd0);
    @(negedge clk);
    check("tmo_done", 32'(bus.frame_done), 32'd1);
    check("tmo_err", 32'(bus.frame_err), 32'd3);
    repeat (2) @(negedge clk);
    check("tmo_done_cnt", 32'(done_seen), 32'd1);
    check("tmo_back_to_hunt", 32'(bus.in_ready), 32'd1);

    // Reset in the middle of a payload.
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'h44);
    bus.in_data  = 8'h55;
    bus.in_valid = 1'b1;
    #1;
    check("mid_pl_valid_before_rst", 32'(bus.pl_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_pl_valid", 32'(bus.pl_valid), 32'd0);
    check("mid_rst_pl_data", 32'(bus.pl_data), 32'd0);
    check("mid_rst_hdr_cmd", 32'(bus.hdr_cmd), 32'd0);
    check("mid_rst_hdr_len", 32'(bus.hdr_len), 32'd0);
    check("mid_rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("mid_rst_frame_done", 32'(bus.frame_done), 32'd0);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_no_done", 32'(done_seen), 32'd0);

    apply_vec(vecs[0], "recover");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_frame_decoder.md
Name: uart_frame_decoder

Overview:
- Consumes the byte stream from the UART receiver over a valid/ready handshake and delineates command frames for the JTAG engine.
- Frame format: SYNC, CMD, LEN, LEN payload bytes, CHK. CHK is the XOR of CMD, LEN and all payload bytes.
- Presents the header on a held handshake and streams the payload through. Reports frame completion or error with a one-cycle status pulse.

Parameters:
- CLK_FREQ, 10_000_000: clock frequency in Hz. Informational; sizes the default timeout.
- TIMEOUT_CYCLES, 100_000: inter-byte timeout in clocks (10 ms at the default clock).
- MAX_LEN, 64: largest legal LEN value.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- in_data  in  8  byte from the UART receiver
- in_valid  in  1  in_data valid
- in_ready  out  1  byte accepted when in_valid && in_ready (drives the receiver's rx_ready)
- hdr_cmd  out  8  command opcode
- hdr_len  out  8  payload length
- hdr_valid  out  1  header available; held until hdr_ready
- hdr_ready  in  1  header accepted
- pl_data  out  8  payload byte
- pl_valid  out  1  payload byte valid
- pl_last  out  1  marks the final payload byte
- pl_ready  in  1  downstream accepts the payload byte
- frame_done  out  1  one-cycle pulse at the end of a frame (good or bad)
- frame_err  out  2  qualified by frame_done: 0 OK, 1 checksum, 2 length, 3 timeout

Behaviour:
- Reset (rst=0, asynchronous):
  - state=HUNT; hdr_valid=0, frame_done=0, frame_err=0, hdr_cmd=0, hdr_len=0.
  - Checksum accumulator, byte counter and timeout counter cleared.
  - Reset mid-frame discards the frame with no frame_done pulse.
- in_ready (combinational from state):
  - 1 in HUNT, CMD, LEN, CSUM.
  - 0 in HDR.
  - Equals pl_ready in PAYLOAD.
- State machine (a transition occurs on a byte accept unless stated otherwise):
  - HUNT: bytes other than SYNC_BYTE are discarded silently. SYNC_BYTE -> CMD, accumulator cleared.
  - CMD: hdr_cmd <= byte, acc ^= byte -> LEN.
  - LEN: acc ^= byte.
    - byte > MAX_LEN: pulse frame_done with err=2 -> HUNT.
    - Otherwise: hdr_len <= byte, byte counter <= byte, hdr_valid <= 1 -> HDR.
  - HDR: hold hdr_cmd, hdr_len and hdr_valid stable. On hdr_valid && hdr_ready, hdr_valid <= 0 and go to PAYLOAD (or to CSUM if LEN=0).
  - PAYLOAD (zero-latency pass-through):
    - pl_data=in_data, pl_valid=in_valid, pl_last=(counter==1).
    - On in_valid && pl_ready: acc ^= byte, counter decrements, and the last byte -> CSUM.
    - Payload is forwarded before the checksum is verified; the consumer must discard its effects when frame_err != 0.
  - CSUM: on accept, byte==acc -> err=0, else err=1. Pulse frame_done -> HUNT.
- Outputs when not in PAYLOAD: pl_valid=0, pl_last=0.
- frame_done and frame_err are registered. frame_err is held until the next pulse; a new frame cannot produce a pulse on the cycle directly after one.
- Timeout:
  - The counter increments each cycle in CMD, LEN, CSUM, and in PAYLOAD with pl_ready=1 and in_valid=0.
  - It clears on every accepted byte and on entry to HUNT.
  - It holds in HUNT, in HDR, and in PAYLOAD while pl_ready=0, so downstream stalls never time out.
  - Reaching TIMEOUT_CYCLES-1 pulses frame_done with err=3 -> HUNT.
  - A byte accepted in the same cycle as the timeout is discarded.
- Counter widths: byte counter 8 bits; timeout counter $clog2(TIMEOUT_CYCLES+1) bits.

Test Plan:
- Good frame: A5 01 02 10 20 33 with hdr_ready and pl_ready tied high -> hdr_cmd=01, hdr_len=02; pl_data 10 then 20 with pl_last on 20; frame_done with err=0.
- Bad checksum plus sync hunting: stream 00 FF A5 01 02 10 20 34 -> leading 00 and FF ignored; payload 10 and 20 forwarded; frame_done with err=1; a following good frame decodes with err=0.
- Length and empty frames: A5 07 41 (MAX_LEN=64) -> err=2, returns to HUNT, no hdr_valid. A5 07 00 07 -> hdr_len=0, no pl_valid, err=0.
- Back-pressure: hold hdr_ready=0 for 50 cycles, then pl_ready=0 for 300 cycles mid-payload (TIMEOUT_CYCLES=200) -> in_ready=0 throughout, header stable, no timeout; frame completes with err=0.
- Timeout and reset: send A5 01 then idle 200 cycles (TIMEOUT_CYCLES=200) -> err=3 on the 200th idle cycle. Assert rst low mid-payload -> all outputs return to 0 immediately and no frame_done pulse.
